// File: rtl/lstm_pkg.sv
// lstm_pkg: shared widths, Q-format constants and MAC state encoding for the LSTM stages
package lstm_pkg;
    localparam int LSTM_DATA_W = 16;
    localparam int LSTM_FRAC   = 8;
    localparam int LSTM_ACC_W  = 40;
    localparam int ONE         = 1 << LSTM_FRAC;
    localparam int HALF_LSB    = 1 << (LSTM_FRAC - 1);
    typedef enum logic [1:0] {ACC, DRAIN, ROUND, OUT} state_t;
endpackage

// File: rtl/lstm_round_sat.sv
// lstm_round_sat: bias-add, round-half-up, rescale and fit to DATA_W; LSTM_MAC_SAT_EN selects saturation over wrap
module lstm_round_sat
    import lstm_pkg::*;
#(
    parameter int DATA_W = LSTM_DATA_W,
    parameter int FRAC   = LSTM_FRAC,
    parameter int ACC_W  = LSTM_ACC_W
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic signed [DATA_W-1:0] i_bias,
    output logic signed [DATA_W-1:0] o_y
);
    logic signed [ACC_W-1:0] w_s;
    logic signed [ACC_W-1:0] w_r;
    assign w_s = i_acc + (ACC_W'(i_bias) <<< FRAC) + (ACC_W'(1) << (FRAC - 1));
    assign w_r = w_s >>> FRAC;
`ifdef LSTM_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] W_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] W_MIN = ~W_MAX;
    assign o_y = (w_r > W_MAX) ? W_MAX[DATA_W-1:0] : (w_r < W_MIN) ? W_MIN[DATA_W-1:0] : w_r[DATA_W-1:0];
`else
    logic w_unused;
    assign w_unused = ^w_r;
    assign o_y = w_r[DATA_W-1:0];
`endif
endmodule

// File: rtl/lstm_layer0_mac.sv
// lstm_layer0_mac: layer-0 product accumulator with drain/round/handshake FSM on the falling clock edge; fit mode set by LSTM_MAC_SAT_EN
module lstm_layer0_mac
    import lstm_pkg::*;
#(
    parameter int DATA_W = LSTM_DATA_W,
    parameter int FRAC   = LSTM_FRAC,
    parameter int ACC_W  = LSTM_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ack,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     ack_mac,
    output logic signed [DATA_W-1:0] y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     drop
);
    state_t                    r_state;
    logic signed [2*DATA_W-1:0] r_p;
    logic                      r_p_valid;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_ack_mac_d;
    logic                      w_rise;
    logic                      w_take;
    logic signed [DATA_W-1:0]  w_y;

    assign w_rise = ack_mac & ~r_ack_mac_d;
    assign w_take = ack && r_state == ACC;

    lstm_round_sat #(.DATA_W(DATA_W), .FRAC(FRAC), .ACC_W(ACC_W)) u_round (
        .i_acc  (r_acc),
        .i_bias (bias),
        .o_y    (w_y)
    );

    // product pipeline, accumulator and result handshake FSM
    always_ff @(negedge clk or negedge rst)
        if (!rst) begin
            r_state     <= ACC;
            r_p         <= '0;
            r_p_valid   <= 1'b0;
            r_acc       <= '0;
            r_ack_mac_d <= 1'b0;
            y           <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            drop        <= 1'b0;
        end else begin
            r_ack_mac_d <= ack_mac;
            r_p_valid   <= w_take;
            if (w_take) r_p <= (2*DATA_W)'(x) * (2*DATA_W)'(w);
            if (ack && !w_take) drop <= 1'b1;
            if (r_p_valid) r_acc <= r_acc + ACC_W'(r_p);
            case (r_state)
                ACC: if (w_rise) begin
                    r_state <= DRAIN;
                    busy    <= 1'b1;
                end
                DRAIN: r_state <= ROUND;
                ROUND: begin
                    y         <= w_y;
                    out_valid <= 1'b1;
                    r_state   <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    r_acc     <= '0;
                    busy      <= 1'b0;
                    r_state   <= ACC;
                end
            endcase
        end
endmodule
